// File: rtl/mul_div_unit.sv
// Iterative unsigned multiply/divide unit for the extended ALU ops.
// One shift-add or restoring-divide step per cycle; the result is written back with a one-cycle strobe.
module mul_div_unit #(
   parameter int WIDTH   = 24,
   parameter int REGADDR = 4
) (
   input  logic               Clock,
   input  logic               Reset_n,
   input  logic               Start,
   input  logic [1:0]         Op,
   input  logic [WIDTH-1:0]   ReadRS,
   input  logic [WIDTH-1:0]   ReadRT,
   input  logic [REGADDR-1:0] DestIn,
   output logic               Busy,
   output logic               Done,
   output logic               RegWrite,
   output logic [WIDTH-1:0]   Result,
   output logic [REGADDR-1:0] DestOut
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t               stateReg, stateNext;
   logic [4:0]           countReg, countNext;
   logic [1:0]           opReg, opNext;
   logic [WIDTH-1:0]     aReg, aNext, bReg, bNext;
   logic [2*WIDTH-1:0]   accReg, accNext;
   logic [WIDTH:0]       remReg, remNext;
   logic [REGADDR-1:0]   destReg, destNext, destOutReg, destOutNext;
   logic [WIDTH-1:0]     resultReg, resultNext;

   logic [WIDTH:0]       mulSum;
   logic [2*WIDTH-1:0]   mulStep;
   logic [WIDTH:0]       divTrial, divDiff, divRem;
   logic                 qBit;
   logic [WIDTH-1:0]     quotStep;

   // Multiply: add multiplicand into the upper half when the multiplier LSB is set, then shift right.
   assign mulSum  = {1'b0, accReg[2*WIDTH-1:WIDTH]} + (accReg[0] ? {1'b0, aReg} : {(WIDTH+1){1'b0}});
   assign mulStep = {mulSum, accReg[WIDTH-1:1]};

   // Divide: the lower half of acc holds the dividend shifting out and the quotient shifting in.
   // Since remainder < divisor, the trial fits in WIDTH+1 bits and bit WIDTH of the difference is the borrow.
   assign divTrial = {remReg[WIDTH-1:0], accReg[WIDTH-1]};
   assign divDiff  = divTrial - {1'b0, bReg};
   assign qBit     = ~divDiff[WIDTH];
   assign divRem   = qBit ? divDiff : divTrial;
   assign quotStep = {accReg[WIDTH-2:0], qBit};

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         stateReg   <= IDLE;
         countReg   <= '0;
         opReg      <= '0;
         aReg       <= '0;
         bReg       <= '0;
         accReg     <= '0;
         remReg     <= '0;
         destReg    <= '0;
         destOutReg <= '0;
         resultReg  <= '0;
      end else begin
         stateReg   <= stateNext;
         countReg   <= countNext;
         opReg      <= opNext;
         aReg       <= aNext;
         bReg       <= bNext;
         accReg     <= accNext;
         remReg     <= remNext;
         destReg    <= destNext;
         destOutReg <= destOutNext;
         resultReg  <= resultNext;
      end
   end

   always_comb begin
      stateNext   = stateReg;
      countNext   = countReg;
      opNext      = opReg;
      aNext       = aReg;
      bNext       = bReg;
      accNext     = accReg;
      remNext     = remReg;
      destNext    = destReg;
      destOutNext = destOutReg;
      resultNext  = resultReg;
      case (stateReg)
         IDLE: begin
            if (Start) begin
               opNext    = Op;
               aNext     = ReadRS;
               bNext     = ReadRT;
               destNext  = DestIn;
               countNext = '0;
               remNext   = '0;
               accNext   = Op[1] ? {{WIDTH{1'b0}}, ReadRS} : {{WIDTH{1'b0}}, ReadRT};
               if (Op[1] && (ReadRT == '0)) begin
                  stateNext   = DONE;
                  resultNext  = Op[0] ? ReadRS : {WIDTH{1'b1}};
                  destOutNext = DestIn;
               end else begin
                  stateNext = RUN;
               end
            end
         end
         RUN: begin
            countNext = countReg + 5'd1;
            accNext   = opReg[1] ? {accReg[2*WIDTH-1:WIDTH], quotStep} : mulStep;
            remNext   = opReg[1] ? divRem : remReg;
            if (countReg == 5'(WIDTH-1)) begin
               stateNext   = DONE;
               destOutNext = destReg;
               case (opReg)
                  2'b00:   resultNext = mulStep[WIDTH-1:0];
                  2'b01:   resultNext = mulStep[2*WIDTH-1:WIDTH];
                  2'b10:   resultNext = quotStep;
                  default: resultNext = divRem[WIDTH-1:0];
               endcase
            end
         end
         DONE:    stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   assign Busy     = (stateReg != IDLE);
   assign Done     = (stateReg == DONE);
   assign RegWrite = (stateReg == DONE);
   assign Result   = resultReg;
   assign DestOut  = destOutReg;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: vector table for results and latency, plus reset and hazard sequences.
module tb_mul_div_unit;

   logic        Clock = 1'b0;
   logic        Reset_n = 1'b0;
   logic        Start = 1'b0;
   logic [1:0]  Op = 2'b00;
   logic [23:0] ReadRS = '0;
   logic [23:0] ReadRT = '0;
   logic [3:0]  DestIn = '0;
   logic        Busy, Done, RegWrite;
   logic [23:0] Result;
   logic [3:0]  DestOut;

   int testsRun = 0;
   int testsFailed = 0;

   mul_div_unit #(.WIDTH(24), .REGADDR(4)) dut (
      .Clock(Clock), .Reset_n(Reset_n), .Start(Start), .Op(Op),
      .ReadRS(ReadRS), .ReadRT(ReadRT), .DestIn(DestIn),
      .Busy(Busy), .Done(Done), .RegWrite(RegWrite),
      .Result(Result), .DestOut(DestOut)
   );

   always #5 Clock = ~Clock;

   typedef struct {
      string       name;
      logic [1:0]  op;
      logic [23:0] a;
      logic [23:0] b;
      logic [3:0]  dest;
      logic [23:0] expResult;
      int          expLatency;
   } vec_t;

   vec_t vecs[13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Issue one operation, scramble operands after the Start edge, then measure latency and busy time.
   task automatic runOp(input vec_t v);
      int cycles;
      int busyCount;
      @(negedge Clock);
      Start = 1'b1; Op = v.op; ReadRS = v.a; ReadRT = v.b; DestIn = v.dest;
      @(posedge Clock); #1;
      Start = 1'b0; ReadRS = 24'($urandom); ReadRT = 24'($urandom); DestIn = 4'($urandom);
      cycles = 1;
      busyCount = 0;
      while (!Done && cycles < 40) begin
         if (Busy) busyCount++;
         @(posedge Clock); #1;
         cycles++;
      end
      if (Busy) busyCount++;
      check({v.name, " done seen"}, 32'(Done), 32'd1);
      check({v.name, " latency"}, 32'(cycles), 32'(v.expLatency));
      check({v.name, " result"}, 32'(Result), 32'(v.expResult));
      check({v.name, " destout"}, 32'(DestOut), 32'(v.dest));
      check({v.name, " regwrite"}, 32'(RegWrite), 32'd1);
      check({v.name, " busy cycles"}, 32'(busyCount), 32'(v.expLatency));
      @(posedge Clock); #1;
      check({v.name, " done pulse width"}, 32'(Done), 32'd0);
      check({v.name, " busy after"}, 32'(Busy), 32'd0);
      check({v.name, " result holds"}, 32'(Result), 32'(v.expResult));
      $display("[TB] %s op=%0d a=0x%0h b=0x%0h -> result=0x%0h latency=%0d", v.name, v.op, v.a, v.b, Result, cycles);
   endtask

   initial begin
      int cycles;
      logic sawDone;

      vecs[0]  = '{"mul3x5",      2'b00, 24'd3,       24'd5,        4'd6,  24'd15,       25};
      vecs[1]  = '{"mulFull",     2'b00, 24'hFFFFFF,  24'hFFFFFF,   4'd1,  24'h000001,   25};
      vecs[2]  = '{"mulhFull",    2'b01, 24'hFFFFFF,  24'hFFFFFF,   4'd2,  24'hFFFFFE,   25};
      vecs[3]  = '{"mulShift",    2'b00, 24'h123456,  24'h000100,   4'd3,  24'h345600,   25};
      vecs[4]  = '{"mulhShift",   2'b01, 24'h123456,  24'h000100,   4'd4,  24'h000012,   25};
      vecs[5]  = '{"divu100by7",  2'b10, 24'd100,     24'd7,        4'd5,  24'd14,       25};
      vecs[6]  = '{"remu100by7",  2'b11, 24'd100,     24'd7,        4'd7,  24'd2,        25};
      vecs[7]  = '{"divuMaxBy1",  2'b10, 24'hFFFFFF,  24'd1,        4'd8,  24'hFFFFFF,   25};
      vecs[8]  = '{"remuMaxBy1",  2'b11, 24'hFFFFFF,  24'd1,        4'd9,  24'd0,        25};
      vecs[9]  = '{"divuBig",     2'b10, 24'd1000000, 24'd1000,     4'd10, 24'd1000,     25};
      vecs[10] = '{"remuBig",     2'b11, 24'd1000001, 24'd1000,     4'd11, 24'd1,        25};
      vecs[11] = '{"divuByZero",  2'b10, 24'd5,       24'd0,        4'd12, 24'hFFFFFF,   1};
      vecs[12] = '{"remuByZero",  2'b11, 24'd5,       24'd0,        4'd13, 24'd5,        1};

      // Reset held with Start asserted: nothing may leave IDLE.
      Start = 1'b1; Op = 2'b00; ReadRS = 24'd3; ReadRT = 24'd5; DestIn = 4'd6;
      for (int i = 0; i < 3; i++) begin
         @(posedge Clock); #1;
         check("reset busy", 32'(Busy), 32'd0);
         check("reset done", 32'(Done), 32'd0);
         check("reset regwrite", 32'(RegWrite), 32'd0);
         check("reset result", 32'(Result), 32'd0);
         check("reset destout", 32'(DestOut), 32'd0);
      end
      $display("[TB] reset hold checked for 3 cycles");
      @(negedge Clock);
      Start = 1'b0;
      Reset_n = 1'b1;

      foreach (vecs[i]) runOp(vecs[i]);

      // Start re-asserted with other operands during RUN must be ignored.
      @(negedge Clock);
      Start = 1'b1; Op = 2'b00; ReadRS = 24'd3; ReadRT = 24'd5; DestIn = 4'd6;
      @(posedge Clock); #1;
      Start = 1'b0;
      cycles = 1;
      sawDone = 1'b0;
      while (!Done && cycles < 40) begin
         if (cycles >= 5 && cycles <= 12) begin
            Start = 1'b1; Op = 2'b10; ReadRS = 24'd99; ReadRT = 24'd9; DestIn = 4'd2;
         end else begin
            Start = 1'b0;
         end
         @(posedge Clock); #1;
         cycles++;
      end
      Start = 1'b0;
      check("hazard start latency", 32'(cycles), 32'd25);
      check("hazard start result", 32'(Result), 32'd15);
      check("hazard start destout", 32'(DestOut), 32'd6);
      @(posedge Clock); #1;
      check("hazard start back to idle", 32'(Busy), 32'd0);
      $display("[TB] start-during-run: result=0x%0h dest=%0d latency=%0d", Result, DestOut, cycles);

      // Asynchronous reset at iteration 10 aborts the operation with no write-back.
      @(negedge Clock);
      Start = 1'b1; Op = 2'b11; ReadRS = 24'd100; ReadRT = 24'd7; DestIn = 4'd9;
      @(posedge Clock); #1;
      Start = 1'b0;
      repeat (10) @(posedge Clock);
      #3;
      check("midrun busy before reset", 32'(Busy), 32'd1);
      Reset_n = 1'b0;
      #1;
      check("midrun reset busy", 32'(Busy), 32'd0);
      check("midrun reset done", 32'(Done), 32'd0);
      check("midrun reset regwrite", 32'(RegWrite), 32'd0);
      check("midrun reset result", 32'(Result), 32'd0);
      check("midrun reset destout", 32'(DestOut), 32'd0);
      @(negedge Clock);
      Reset_n = 1'b1;
      sawDone = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge Clock); #1;
         if (Done || RegWrite || Busy) sawDone = 1'b1;
      end
      check("midrun reset no writeback", 32'(sawDone), 32'd0);
      $display("[TB] reset-during-run: activity after reset=%0d", sawDone);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
